// File: rtl/pwm_chase_sequencer.sv
// pwm_chase_sequencer
// Autonomous 4-LED brightness sequencer. A free-running PWM counter drives one
// compare per channel. A step-rate state machine fades one channel at a time
// up, holds it at full scale, fades it down, then moves on to the next channel.
// The linear duty of every channel is exported on duty_bus.
// Build option: define PWM_GAMMA_EN to apply square-law correction to the PWM
// compare. duty_bus keeps reporting the linear duty in either build.
module pwm_chase_sequencer #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned N_CH         = 4,
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned DUTY_STEP    = 16,
  parameter int unsigned HOLD_STEPS   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic [N_CH-1:0]           led,
  output logic [N_CH*CNT_W-1:0]     duty_bus,
  output logic [$clog2(N_CH)-1:0]   active_ch,
  output logic                      busy,
  output logic                      cycle_done
);

  localparam int unsigned CH_W   = $clog2(N_CH);
  localparam int unsigned PER_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [CNT_W-1:0]  MAX       = '1;
  localparam logic [CNT_W:0]    STEP_X    = (CNT_W+1)'(DUTY_STEP);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(STEP_PERIODS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    HOLD,
    DOWN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   pwm_cnt;
  logic [PER_W-1:0]   per_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]   duty [N_CH];
  logic [CNT_W-1:0]   eff  [N_CH];

  logic               period_end;
  logic               step_tick;
  logic [CNT_W-1:0]   cur_duty;
  logic [CNT_W:0]     sum_x;
  logic [CNT_W:0]     diff_x;
  logic [CNT_W-1:0]   up_duty;
  logic [CNT_W-1:0]   dn_duty;

  assign period_end = (pwm_cnt == MAX);
  assign step_tick  = period_end && (per_cnt == PER_LAST);

  // Free-running PWM timebase; runs regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Counts PWM periods per sequencer step; parked at zero while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (!en) begin
      per_cnt <= '0;
    end else if (step_tick) begin
      per_cnt <= '0;
    end else if (period_end) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // Saturating fade arithmetic on the active channel, one bit wider than duty.
  always_comb begin
    cur_duty = duty[active_ch];
    sum_x    = {1'b0, cur_duty} + STEP_X;
    diff_x   = {1'b0, cur_duty} - STEP_X;
    up_duty  = (sum_x > {1'b0, MAX}) ? MAX : sum_x[CNT_W-1:0];
    dn_duty  = diff_x[CNT_W] ? '0 : diff_x[CNT_W-1:0];
  end

  // Sequencer FSM: steps only on step_tick, which coincides with the PWM wrap,
  // so each PWM period sees a single duty value. Losing en overrides a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      active_ch  <= '0;
      hold_cnt   <= '0;
      cycle_done <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        duty[i] <= '0;
      end
    end else begin
      cycle_done <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        busy      <= 1'b0;
        active_ch <= '0;
        hold_cnt  <= '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
          duty[i] <= '0;
        end
      end else if (step_tick) begin
        case (state)
          IDLE: begin
            state <= UP;
            busy  <= 1'b1;
          end
          UP: begin
            duty[active_ch] <= up_duty;
            if (up_duty == MAX) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
          HOLD: begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) begin
              state <= DOWN;
            end
          end
          DOWN: begin
            duty[active_ch] <= dn_duty;
            if (dn_duty == '0) begin
              state      <= UP;
              active_ch  <= (active_ch == CH_LAST) ? '0 : active_ch + 1'b1;
              cycle_done <= (active_ch == CH_LAST);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Debug/export view of the linear duty registers.
  always_comb begin
    duty_bus = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      duty_bus[i*CNT_W +: CNT_W] = duty[i];
    end
  end

`ifdef PWM_GAMMA_EN
  // Square-law correction: eff = duty^2 >> CNT_W on a full-width product.
  always_comb begin
    logic [2*CNT_W-1:0] prod;
    prod = '0;
    eff  = '{default: '0};
    for (int unsigned i = 0; i < N_CH; i++) begin
      prod   = {{CNT_W{1'b0}}, duty[i]} * {{CNT_W{1'b0}}, duty[i]};
      eff[i] = CNT_W'(prod >> CNT_W);
    end
  end
`else
  // Linear build: the compare uses the duty register directly.
  always_comb begin
    eff = '{default: '0};
    for (int unsigned i = 0; i < N_CH; i++) begin
      eff[i] = duty[i];
    end
  end
`endif

  // Registered PWM compare; led lags the counter by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        led[i] <= (pwm_cnt < eff[i]);
      end
    end
  end

endmodule
